// File: rtl/ttl_74153_scan_pkg.sv
// Shared defaults and the common input-unpacking macro for the scanning 74153 mux.
// The macro lives here so every file compiled after the package can use it.
`ifndef TTL_ASSIGN_UNPACK_DEFINED
`define TTL_ASSIGN_UNPACK_DEFINED
`define ASSIGN_UNPACK(PK_WIDTH, PK_LEN, UNPK_DEST, PK_SRC) \
  for (genvar gi = 0; gi < (PK_LEN); gi++) begin : g_unpack \
    assign UNPK_DEST[gi] = PK_SRC[(PK_WIDTH)*gi +: (PK_WIDTH)]; \
  end
`endif

package ttl_74153_scan_pkg;
  localparam int DEFAULT_BLOCKS   = 2;
  localparam int DEFAULT_WIDTH_IN = 4;
endpackage

// File: rtl/ttl_scan_counter.sv
// Channel register: load with clamp, modulo-WIDTH_IN scan advance, wrap pulse.
module ttl_scan_counter
  import ttl_74153_scan_pkg::*;
#(
  parameter int WIDTH_IN     = DEFAULT_WIDTH_IN,
  parameter int WIDTH_SELECT = $clog2(WIDTH_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_bar,
  input  logic                    scan,
  input  logic [WIDTH_SELECT-1:0] select,
  output logic [WIDTH_SELECT-1:0] channel,
  output logic                    wrap
);
  localparam logic [WIDTH_SELECT-1:0] LAST_CH = WIDTH_SELECT'(WIDTH_IN - 1);

  logic [WIDTH_SELECT-1:0] channel_q, channel_d;
  logic [WIDTH_SELECT-1:0] select_clamped;
  logic                    wrap_q, wrap_d;

  always_comb begin
    select_clamped = (select > LAST_CH) ? LAST_CH : select;
    channel_d      = channel_q;
    wrap_d         = 1'b0;
    // Load beats scan, and a load never produces a wrap pulse.
    if (!load_bar) begin
      channel_d = select_clamped;
    end else if (scan) begin
      if (channel_q == LAST_CH) begin
        channel_d = '0;
        wrap_d    = 1'b1;
      end else begin
        channel_d = channel_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      channel_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      channel_q <= channel_d;
      wrap_q    <= wrap_d;
    end
  end

  assign channel = channel_q;
  assign wrap    = wrap_q;
endmodule

// File: rtl/ttl_74153_scan.sv
// Multi-block 74153-style multiplexer with registered outputs and a scanning
// channel register shared by all blocks.
module ttl_74153_scan
  import ttl_74153_scan_pkg::*;
#(
  parameter int BLOCKS       = DEFAULT_BLOCKS,
  parameter int WIDTH_IN     = DEFAULT_WIDTH_IN,
  parameter int WIDTH_SELECT = $clog2(WIDTH_IN),
  parameter int DELAY_RISE   = 0,
  parameter int DELAY_FALL   = 0
) (
  input  logic                       Clk,
  input  logic                       Clear,
  input  logic                       Load_bar,
  input  logic                       Scan,
  input  logic [WIDTH_SELECT-1:0]    Select,
  input  logic [BLOCKS-1:0]          Enable_bar,
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic [BLOCKS-1:0]          Y,
  output logic [WIDTH_SELECT-1:0]    Channel,
  output logic                       Wrap
);
  logic [BLOCKS-1:0] a_unpk [WIDTH_IN];
  logic [BLOCKS-1:0] y_q, y_d;

  `ASSIGN_UNPACK(BLOCKS, WIDTH_IN, a_unpk, A_2D)

  ttl_scan_counter #(
    .WIDTH_IN    (WIDTH_IN),
    .WIDTH_SELECT(WIDTH_SELECT)
  ) u_counter (
    .clk     (Clk),
    .rst     (Clear),
    .load_bar(Load_bar),
    .scan    (Scan),
    .select  (Select),
    .channel (Channel),
    .wrap    (Wrap)
  );

  // Capture uses the channel value from before the edge.
  always_comb begin
    y_d = a_unpk[Channel] & ~Enable_bar;
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) y_q <= '0;
    else       y_q <= y_d;
  end

  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_y_direct
    assign Y = y_q;
  end else begin : g_y_delayed
    for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_bit
      always @(y_q[gi]) begin
        if (y_q[gi]) Y[gi] <= #(DELAY_RISE) 1'b1;
        else         Y[gi] <= #(DELAY_FALL) 1'b0;
      end
    end
  end
endmodule
